// File: rtl/lif_pkg.sv
// Shared constants and sizing helpers for the spike/weight byte loader.
package lif_pkg;

  localparam int   BYTE_W     = 8;
  localparam logic SEL_WEIGHT = 1'b0;
  localparam logic SEL_SPIKE  = 1'b1;

  // Width of a full weight/spike vector for a given stage count.
  function automatic int VEC_W(input int n);
    return 2 ** n;
  endfunction

  // Number of bus bytes needed to fill one vector.
  function automatic int BYTES_PER_VEC(input int n);
    return (2 ** n) / BYTE_W;
  endfunction

endpackage

// File: rtl/spike_weight_loader_if.sv
// Byte-serial load bus between a byte source and the spike/weight loader.
interface spike_weight_loader_if;

  logic [lif_pkg::BYTE_W-1:0] in_data;
  logic                       in_sel;
  logic                       in_valid;
  logic                       in_ready;
  logic                       hold_w;
  logic                       flush;

  modport master (
    output in_data, in_sel, in_valid, hold_w, flush,
    input  in_ready
  );

  modport slave (
    input  in_data, in_sel, in_valid, hold_w, flush,
    output in_ready
  );

endinterface

// File: rtl/byte_shift_reg.sv
// Shadow vector that fills one byte at a time from the top, with a byte
// counter and a full flag. Clearing only resets the counter; the stale
// shadow bits are overwritten by the next frame anyway.
module byte_shift_reg
  import lif_pkg::*;
#(
  parameter int N_STAGE = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       shift_en,
  input  logic [BYTE_W-1:0]          byte_in,
  output logic [VEC_W(N_STAGE)-1:0]  vec,
  output logic [N_STAGE-3:0]         count,
  output logic                       full
);

  localparam int                W        = VEC_W(N_STAGE);
  localparam int                CNT_W    = N_STAGE - 2;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BYTES_PER_VEC(N_STAGE));

  logic [W-1:0]        r_vec;
  logic [CNT_W-1:0]    r_count;
  logic [W+BYTE_W-1:0] w_cat;
  logic [W-1:0]        w_shifted;

  // New byte enters at the top; the oldest byte drifts down to bits [7:0].
  // Concatenating first keeps this valid even when W equals one byte.
  assign w_cat     = {byte_in, r_vec};
  assign w_shifted = w_cat[W+BYTE_W-1:BYTE_W];

  // Shadow data and byte count; clear wins over a shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (shift_en) begin
      r_vec   <= w_shifted;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign vec   = r_vec;
  assign count = r_count;
  assign full  = (r_count == CNT_FULL);

endmodule

// File: rtl/spike_weight_loader.sv
// Byte-serial front end for the MAC. Weight and spike bytes fill two shadow
// registers; once a frame is complete the shadows are committed to the
// active vectors, which otherwise stay stable for the MAC and neuron.
module spike_weight_loader
  import lif_pkg::*;
#(
  parameter int N_STAGE = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  spike_weight_loader_if.slave       bus,
  output logic [VEC_W(N_STAGE)-1:0]  w_out,
  output logic [VEC_W(N_STAGE)-1:0]  x_out,
  output logic                       vec_valid,
  output logic [N_STAGE-3:0]         w_count,
  output logic [N_STAGE-3:0]         x_count
);

  localparam int W = VEC_W(N_STAGE);

  logic [W-1:0] w_wt_vec;
  logic [W-1:0] w_sp_vec;
  logic         w_wt_full;
  logic         w_sp_full;
  logic         w_sel_full;
  logic         w_accept;
  logic         w_wt_shift;
  logic         w_sp_shift;
  logic         w_commit;
  logic         w_wt_clear;
  logic         w_sp_clear;

  logic [W-1:0] r_w_out;
  logic [W-1:0] r_x_out;
  logic         r_vec_valid;

  // A byte is refused only when its own target is full, so the other
  // target keeps loading while one waits for commit.
  assign w_sel_full   = (bus.in_sel == SEL_SPIKE) ? w_sp_full : w_wt_full;
  assign bus.in_ready = ~reset & ~bus.flush & ~w_sel_full;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_wt_shift   = w_accept & (bus.in_sel == SEL_WEIGHT);
  assign w_sp_shift   = w_accept & (bus.in_sel == SEL_SPIKE);

  // Commit is decided from registered counts, so it lands one edge after
  // the completing byte. Flush cancels a pending commit. Only targets that
  // are committed get their count cleared, so a byte accepted for a
  // non-full target in the commit cycle survives.
  assign w_commit   = w_sp_full & (w_wt_full | bus.hold_w) & ~bus.flush;
  assign w_wt_clear = bus.flush | (w_commit & ~bus.hold_w);
  assign w_sp_clear = bus.flush | w_commit;

  byte_shift_reg #(.N_STAGE(N_STAGE)) u_wt_shadow (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_wt_clear),
    .shift_en (w_wt_shift),
    .byte_in  (bus.in_data),
    .vec      (w_wt_vec),
    .count    (w_count),
    .full     (w_wt_full)
  );

  byte_shift_reg #(.N_STAGE(N_STAGE)) u_sp_shadow (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_sp_clear),
    .shift_en (w_sp_shift),
    .byte_in  (bus.in_data),
    .vec      (w_sp_vec),
    .count    (x_count),
    .full     (w_sp_full)
  );

  // Active vectors change only here, on commit or reset; vec_valid marks
  // the cycle right after a commit edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_out     <= '0;
      r_x_out     <= '0;
      r_vec_valid <= 1'b0;
    end else begin
      r_vec_valid <= w_commit;
      if (w_commit) begin
        r_x_out <= w_sp_vec;
        if (!bus.hold_w) begin
          r_w_out <= w_wt_vec;
        end
      end
    end
  end

  assign w_out     = r_w_out;
  assign x_out     = r_x_out;
  assign vec_valid = r_vec_valid;

endmodule

// File: tb/tb_spike_weight_loader.sv
// Directed self-checking bench for spike_weight_loader: a per-cycle vector
// table for reset and a full frame, then hand-written sequences for
// backpressure, hold_w, flush, mid-frame reset and the 1-byte-frame build.
module tb_spike_weight_loader;

  logic        clk;
  logic        reset;
  logic [63:0] w_out, x_out;
  logic        vv;
  logic [3:0]  wc, xc;
  logic [7:0]  w_out3, x_out3;
  logic        vv3;
  logic [0:0]  wc3, xc3;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] W1 = 64'h0807060504030201;
  localparam logic [63:0] X1 = 64'hF7F6F5F4F3F2F1F0;
  localparam logic [63:0] X3 = 64'h3837363534333231;
  localparam logic [63:0] X4 = 64'h5555555555555555;

  spike_weight_loader_if bus ();
  spike_weight_loader_if bus3 ();

  spike_weight_loader #(.N_STAGE(6)) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .w_out(w_out), .x_out(x_out), .vec_valid(vv),
    .w_count(wc), .x_count(xc)
  );

  spike_weight_loader #(.N_STAGE(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3),
    .w_out(w_out3), .x_out(x_out3), .vec_valid(vv3),
    .w_count(wc3), .x_count(xc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, valid, sel, hold, flush;
    logic [7:0]  data;
    logic        exp_ready;
    logic [3:0]  exp_wc, exp_xc;
    logic        exp_vv;
    logic [63:0] exp_w, exp_x;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic valid, logic sel, logic [7:0] data,
                              logic ready, logic [3:0] ewc, logic [3:0] exc,
                              logic evv, logic [63:0] ew, logic [63:0] ex);
    vec_t v;
    v.rst = rst; v.valid = valid; v.sel = sel; v.data = data;
    v.hold = 1'b0; v.flush = 1'b0;
    v.exp_ready = ready; v.exp_wc = ewc; v.exp_xc = exc; v.exp_vv = evv;
    v.exp_w = ew; v.exp_x = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic valid, input logic sel,
                       input logic [7:0] data, input logic hold, input logic flush);
    reset        = rst;
    bus.in_valid = valid;
    bus.in_sel   = sel;
    bus.in_data  = data;
    bus.hold_w   = hold;
    bus.flush    = flush;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] ewc, input logic [3:0] exc,
                             input logic evv, input logic [63:0] ew, input logic [63:0] ex);
    chk({tag, "_wc"}, 64'(wc), 64'(ewc));
    chk({tag, "_xc"}, 64'(xc), 64'(exc));
    chk({tag, "_vv"}, 64'(vv), 64'(evv));
    chk({tag, "_w"},  w_out, ew);
    chk({tag, "_x"},  x_out, ex);
  endtask

  // Offer one byte on the 64-bit bus, require it to be accepted, and clock it in.
  task automatic send(input string tag, input logic sel, input logic [7:0] data, input logic hold);
    drive(1'b0, 1'b1, sel, data, hold, 1'b0);
    #2;
    chk({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    step();
  endtask

  // Same for the 1-byte-frame build.
  task automatic send3(input string tag, input logic sel, input logic [7:0] data);
    bus3.in_valid = 1'b1;
    bus3.in_sel   = sel;
    bus3.in_data  = data;
    #2;
    chk({tag, "_ready"}, 64'(bus3.in_ready), 64'd1);
    step();
    bus3.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    bus3.in_valid = 1'b0; bus3.in_sel = 1'b0; bus3.in_data = 8'h00;
    bus3.hold_w = 1'b0;   bus3.flush = 1'b0;

    // Reset with bytes offered, then one full frame with hold_w = 0.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 4'd0, 4'd0, 1'b0, 64'd0, 64'd0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 8'(k + 1), 1'b1, 4'(k), 4'd0, 1'b0, 64'd0, 64'd0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b1, 8'(8'hF0 + k), 1'b1, 4'd8, 4'(k), 1'b0, 64'd0, 64'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 4'd8, 4'd8, 1'b0, 64'd0, 64'd0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 4'd0, 1'b1, W1, X1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 4'd0, 1'b0, W1, X1));

    step();
    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].rst, tbl[r].valid, tbl[r].sel, tbl[r].data, tbl[r].hold, tbl[r].flush);
      #2;
      chk($sformatf("row%0d_ready", r), 64'(bus.in_ready), 64'(tbl[r].exp_ready));
      check_state($sformatf("row%0d", r), tbl[r].exp_wc, tbl[r].exp_xc, tbl[r].exp_vv,
                  tbl[r].exp_w, tbl[r].exp_x);
      step();
    end

    // Backpressure: a 9th weight byte stalls while spike bytes keep flowing.
    for (int k = 0; k < 8; k++) send("bp_w", 1'b0, 8'(k + 1), 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    #2;
    chk("bp_stall_ready", 64'(bus.in_ready), 64'd0);
    step();
    chk("bp_stall_wc", 64'(wc), 64'd8);
    for (int k = 0; k < 8; k++) send("bp_x", 1'b1, 8'(8'h31 + k), 1'b0);
    drive(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    #2;
    chk("bp_commit_cycle_ready", 64'(bus.in_ready), 64'd0);
    check_state("bp_precommit", 4'd8, 4'd8, 1'b0, W1, X1);
    step();
    #2;
    chk("bp_after_ready", 64'(bus.in_ready), 64'd1);
    check_state("bp_commit", 4'd0, 4'd0, 1'b1, W1, X3);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    check_state("bp_aa", 4'd1, 4'd0, 1'b0, W1, X3);

    // hold_w = 1: commit spikes only; a weight byte in the commit cycle is kept.
    for (int k = 0; k < 8; k++) send("hold_x", 1'b1, 8'h55, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 8'hBB, 1'b1, 1'b0);
    #2;
    chk("hold_commit_cycle_ready", 64'(bus.in_ready), 64'd1);
    check_state("hold_precommit", 4'd1, 4'd8, 1'b0, W1, X3);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    check_state("hold_commit", 4'd2, 4'd0, 1'b1, W1, X4);
    step();
    chk("hold_pulse_end", 64'(vv), 64'd0);

    // Flush beats an offered byte.
    for (int k = 0; k < 5; k++) send("fl_x", 1'b1, 8'h66, 1'b0);
    chk("fl_xc5", 64'(xc), 64'd5);
    drive(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
    #2;
    chk("fl_ready", 64'(bus.in_ready), 64'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    check_state("fl_after", 4'd0, 4'd0, 1'b0, W1, X4);
    step();
    chk("fl_no_pulse", 64'(vv), 64'd0);

    // Flush beats a pending commit.
    for (int k = 0; k < 8; k++) send("flc_x", 1'b1, 8'h99, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    check_state("flc_after", 4'd0, 4'd0, 1'b0, W1, X4);
    step();
    chk("flc_no_pulse", 64'(vv), 64'd0);

    // Reset on the would-be commit edge.
    for (int k = 0; k < 3; k++) send("rst_w", 1'b0, 8'(8'h11 + k), 1'b1);
    for (int k = 0; k < 8; k++) send("rst_x", 1'b1, 8'h22, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    #2;
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    check_state("rst_after", 4'd0, 4'd0, 1'b0, 64'd0, 64'd0);
    step();
    chk("rst_no_pulse", 64'(vv), 64'd0);

    // 1-byte frames: each byte fills its target immediately.
    send3("n3_w", 1'b0, 8'h5A);
    chk("n3_wc_full", 64'(wc3), 64'd1);
    bus3.in_valid = 1'b1; bus3.in_sel = 1'b0; bus3.in_data = 8'h77;
    #2;
    chk("n3_w_stall_ready", 64'(bus3.in_ready), 64'd0);
    step();
    send3("n3_x", 1'b1, 8'hC3);
    chk("n3_pre_xc", 64'(xc3), 64'd1);
    chk("n3_pre_vv", 64'(vv3), 64'd0);
    step();
    chk("n3_vv", 64'(vv3), 64'd1);
    chk("n3_w", 64'(w_out3), 64'h5A);
    chk("n3_x", 64'(x_out3), 64'hC3);
    chk("n3_wc0", 64'(wc3), 64'd0);
    chk("n3_xc0", 64'(xc3), 64'd0);
    step();
    chk("n3_pulse_end", 64'(vv3), 64'd0);
    send3("n3r_w", 1'b0, 8'h12);
    send3("n3r_x", 1'b1, 8'h34);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #2;
    chk("n3r_w", 64'(w_out3), 64'd0);
    chk("n3r_x", 64'(x_out3), 64'd0);
    chk("n3r_vv", 64'(vv3), 64'd0);
    chk("n3r_wc", 64'(wc3), 64'd0);
    step();
    chk("n3r_no_pulse", 64'(vv3), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
